// File: rtl/vga_timing_decoder.sv
// VGA sync receiver: measures h/v sync periods, locks to the configured mode and regenerates
// pixel coordinates plus display enable. Define VGA_RX_SYNC_EN to add 2-flop input synchronizers.
module vga_timing_decoder #(
    parameter int H_DISPLAY = 640,
    parameter int H_TOTAL   = 800,
    parameter int H_SYNC    = 96,
    parameter int H_BPORCH  = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_TOTAL   = 525,
    parameter int V_SYNC    = 2,
    parameter int V_BPORCH  = 33,
    parameter int H_TOL     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic [7:0] lock_loss_cnt
);
    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [11:0]        PERIOD_MIN = 12'(H_TOTAL - H_TOL);
    localparam logic [11:0]        PERIOD_MAX = 12'(H_TOTAL + H_TOL);
    localparam logic [10:0]        H_TIMEOUT  = 11'(H_TOTAL + H_TOL + 1);
    localparam logic [10:0]        LINES_GOOD = 11'(V_TOTAL);
    localparam logic signed [12:0] X_OFS      = 13'(H_SYNC + H_BPORCH);
    localparam logic signed [12:0] Y_OFS      = 13'(V_SYNC + V_BPORCH);
    localparam logic signed [12:0] X_LIM      = 13'(H_DISPLAY);
    localparam logic signed [12:0] Y_LIM      = 13'(V_DISPLAY);

    logic h_s;
    logic v_s;

`ifdef VGA_RX_SYNC_EN
    logic [1:0] h_meta_q, h_meta_d;
    logic [1:0] v_meta_q, v_meta_d;

    always_comb begin
        h_meta_d = {h_meta_q[0], h_sync_in};
        v_meta_d = {v_meta_q[0], v_sync_in};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_meta_q <= 2'b00;
            v_meta_q <= 2'b00;
        end else begin
            h_meta_q <= h_meta_d;
            v_meta_q <= v_meta_d;
        end
    end

    assign h_s = h_meta_q[1];
    assign v_s = v_meta_q[1];
`else
    assign h_s = h_sync_in;
    assign v_s = v_sync_in;
`endif

    logic        h_prev_q, h_prev_d;
    logic        v_prev_q, v_prev_d;
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic        vs_pend_q, vs_pend_d;
    state_t      state_q, state_d;
    logic [7:0]  loss_q, loss_d;
    logic [9:0]  pos_x_q, pos_x_d;
    logic [9:0]  pos_y_q, pos_y_d;
    logic        video_on_q, video_on_d;
    logic        locked_q, locked_d;
    logic        frame_start_q, frame_start_d;

    logic               h_fall, v_fall, boundary, line_good, timeout, bad_line, frame_good;
    logic [11:0]        period;
    logic signed [12:0] x_s, y_s;

    always_comb begin
        h_prev_d = h_s;
        v_prev_d = v_s;
        // Prior sample is registered, current sample is the (optionally synchronized) input.
        h_fall   = h_prev_q & ~h_s;
        v_fall   = v_prev_q & ~v_s;

        period     = {1'b0, h_cnt_q} + 12'd1;
        line_good  = (period >= PERIOD_MIN) && (period <= PERIOD_MAX);
        timeout    = !h_fall && (h_cnt_q == H_TIMEOUT);
        bad_line   = (h_fall && !line_good) || timeout;
        boundary   = h_fall && (vs_pend_q || v_fall);
        frame_good = ({1'b0, line_cnt_q} + 11'd1) == LINES_GOOD;

        if (h_fall)              h_cnt_d = '0;
        else if (&h_cnt_q)       h_cnt_d = h_cnt_q;
        else                     h_cnt_d = h_cnt_q + 11'd1;

        if (boundary)                    line_cnt_d = '0;
        else if (h_fall && !(&line_cnt_q)) line_cnt_d = line_cnt_q + 10'd1;
        else                             line_cnt_d = line_cnt_q;

        if (boundary)    vs_pend_d = 1'b0;
        else if (v_fall) vs_pend_d = 1'b1;
        else             vs_pend_d = vs_pend_q;

        state_d = state_q;
        loss_d  = loss_q;
        case (state_q)
            ST_SEARCH: begin
                if (!bad_line && boundary) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (bad_line)                    state_d = ST_SEARCH;
                else if (boundary && frame_good) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (bad_line || (boundary && !frame_good)) begin
                    state_d = ST_SEARCH;
                    if (!(&loss_q)) loss_d = loss_q + 8'd1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase

        // Outputs use next state so video_on and locked drop together on a lock loss.
        x_s           = $signed({2'b00, h_cnt_q}) - X_OFS;
        y_s           = $signed({3'b000, line_cnt_q}) - Y_OFS;
        locked_d      = (state_d == ST_LOCKED);
        video_on_d    = locked_d && (x_s >= 13'sd0) && (x_s < X_LIM)
                                 && (y_s >= 13'sd0) && (y_s < Y_LIM);
        pos_x_d       = video_on_d ? x_s[9:0] : 10'd0;
        pos_y_d       = video_on_d ? y_s[9:0] : 10'd0;
        frame_start_d = boundary && locked_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_prev_q      <= 1'b0;
            v_prev_q      <= 1'b0;
            h_cnt_q       <= '0;
            line_cnt_q    <= '0;
            vs_pend_q     <= 1'b0;
            state_q       <= ST_SEARCH;
            loss_q        <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            video_on_q    <= 1'b0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_prev_q      <= h_prev_d;
            v_prev_q      <= v_prev_d;
            h_cnt_q       <= h_cnt_d;
            line_cnt_q    <= line_cnt_d;
            vs_pend_q     <= vs_pend_d;
            state_q       <= state_d;
            loss_q        <= loss_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            video_on_q    <= video_on_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pos_x         = pos_x_q;
    assign pos_y         = pos_y_q;
    assign video_on      = video_on_q;
    assign locked        = locked_q;
    assign frame_start   = frame_start_q;
    assign lock_loss_cnt = loss_q;
endmodule
